// File: rtl/spike_rate_monitor.sv
// spike_rate_monitor: counts rising-edge spike events per fixed window and measures inter-spike interval.
// Latency: window result registered on the window-end edge; ISI registered on the edge that samples the event.
// Backpressure: rate result held under valid/ready; a new window overwrites unconsumed data and sets a sticky overrun.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   enable                measurement enable (dropping it discards the partial window and the ISI reference)
//   spike_in              raw spike line; only rising edges count
//   rate_data/valid/ready spike count of the last completed window, valid/ready handshake
//   rate_overrun          sticky: a window result replaced unconsumed data; cleared by clr_overrun
//   isi_out, isi_strobe   last inter-spike interval in cycles, one-cycle update pulse
module spike_rate_monitor #(
  parameter int WINDOW_CYCLES = 256,
  parameter int CNT_W         = 8,
  parameter int ISI_W         = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             spike_in,
  output logic [CNT_W-1:0] rate_data,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic             rate_overrun,
  input  logic             clr_overrun,
  output logic [ISI_W-1:0] isi_out,
  output logic             isi_strobe
);

  localparam int WIN_W = $clog2(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [ISI_W-1:0] ISI_MAX  = '1;

  localparam logic [0:0] W_IDLE  = 1'b0;
  localparam logic [0:0] W_RUN   = 1'b1;
  localparam logic [0:0] I_NOREF = 1'b0;
  localparam logic [0:0] I_REF   = 1'b1;

  logic             spike_d_q, spike_d_d;
  logic [0:0]       win_state_q, win_state_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] spk_cnt_q, spk_cnt_d;
  logic [CNT_W-1:0] rate_data_q, rate_data_d;
  logic             rate_valid_q, rate_valid_d;
  logic             rate_overrun_q, rate_overrun_d;
  logic [0:0]       isi_state_q, isi_state_d;
  logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d;
  logic [ISI_W-1:0] isi_out_q, isi_out_d;
  logic             isi_strobe_q, isi_strobe_d;

  logic             evt;
  logic             win_end;
  logic [CNT_W-1:0] spk_sum;
  logic [ISI_W-1:0] isi_inc;

  always_comb begin
    // Edge detect uses the registered line even while disabled, so a spike
    // already high at enable time is not mistaken for a fresh event.
    evt       = spike_in & ~spike_d_q & enable;
    spike_d_d = spike_in;

    // Saturating count including this cycle's event.
    spk_sum = spk_cnt_q;
    if (evt && (spk_cnt_q != CNT_MAX)) begin
      spk_sum = spk_cnt_q + 1'b1;
    end

    isi_inc = isi_cnt_q;
    if (isi_cnt_q != ISI_MAX) begin
      isi_inc = isi_cnt_q + 1'b1;
    end

    win_state_d    = win_state_q;
    win_cnt_d      = win_cnt_q;
    spk_cnt_d      = spk_cnt_q;
    win_end        = 1'b0;

    if (win_state_q == W_IDLE) begin
      if (enable) begin
        win_state_d = W_RUN;
        win_cnt_d   = '0;
        spk_cnt_d   = '0;
      end
    end else begin
      if (!enable) begin
        // Partial window is discarded without producing a result.
        win_state_d = W_IDLE;
        win_cnt_d   = '0;
        spk_cnt_d   = '0;
      end else if (win_cnt_q == WIN_LAST) begin
        // Back-to-back windows: next window starts on the following cycle.
        win_end   = 1'b1;
        win_cnt_d = '0;
        spk_cnt_d = '0;
      end else begin
        win_cnt_d = win_cnt_q + 1'b1;
        spk_cnt_d = spk_sum;
      end
    end

    rate_data_d  = rate_data_q;
    rate_valid_d = rate_valid_q;
    if (win_end) begin
      rate_data_d  = spk_sum;
      rate_valid_d = 1'b1;
    end else if (rate_valid_q && rate_ready) begin
      rate_valid_d = 1'b0;
    end

    // Set has priority over clear when both happen in the same cycle.
    rate_overrun_d = rate_overrun_q;
    if (win_end && rate_valid_q && !rate_ready) begin
      rate_overrun_d = 1'b1;
    end else if (clr_overrun) begin
      rate_overrun_d = 1'b0;
    end

    isi_state_d  = isi_state_q;
    isi_cnt_d    = isi_cnt_q;
    isi_out_d    = isi_out_q;
    isi_strobe_d = 1'b0;
    if (!enable) begin
      isi_state_d = I_NOREF;
      isi_cnt_d   = '0;
    end else if (isi_state_q == I_NOREF) begin
      if (evt) begin
        isi_state_d = I_REF;
        isi_cnt_d   = '0;
      end
    end else begin
      if (evt) begin
        // +1 turns "cycles since the previous edge" into edge-to-edge distance.
        isi_out_d    = isi_inc;
        isi_strobe_d = 1'b1;
        isi_cnt_d    = '0;
      end else begin
        isi_cnt_d = isi_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spike_d_q      <= 1'b0;
      win_state_q    <= W_IDLE;
      win_cnt_q      <= '0;
      spk_cnt_q      <= '0;
      rate_data_q    <= '0;
      rate_valid_q   <= 1'b0;
      rate_overrun_q <= 1'b0;
      isi_state_q    <= I_NOREF;
      isi_cnt_q      <= '0;
      isi_out_q      <= '0;
      isi_strobe_q   <= 1'b0;
    end else begin
      spike_d_q      <= spike_d_d;
      win_state_q    <= win_state_d;
      win_cnt_q      <= win_cnt_d;
      spk_cnt_q      <= spk_cnt_d;
      rate_data_q    <= rate_data_d;
      rate_valid_q   <= rate_valid_d;
      rate_overrun_q <= rate_overrun_d;
      isi_state_q    <= isi_state_d;
      isi_cnt_q      <= isi_cnt_d;
      isi_out_q      <= isi_out_d;
      isi_strobe_q   <= isi_strobe_d;
    end
  end

  assign rate_data    = rate_data_q;
  assign rate_valid   = rate_valid_q;
  assign rate_overrun = rate_overrun_q;
  assign isi_out      = isi_out_q;
  assign isi_strobe   = isi_strobe_q;

endmodule
